weight_compress: RTL and testbench
==================================

Name: weight_compress

Overview:
- Encoder counterpart of the sparse-weight decoder in the PE array.
- Accepts one dense 3x3 kernel of 8-bit weights per handshake.
- Produces the 9-bit nonzero flag mask (one wr_req_wei_flag write strobe) and the per-row valid counts.
- Then streams only the nonzero weights in raster order over a valid/ready interface toward the weight buffer.
- In dense mode, all 9 weights are streamed and the flag is all ones.

Parameters:
DATA_WIDTH, 8, weight width in bits
KERNEL_WIDTH, 3, kernel rows/cols; the block supports only 3
KERNEL_SIZE, 9, weights per kernel (KERNEL_WIDTH squared)
WEI_INDEX_WIDTH, 2, width of row/col index and per-row count

Ports:
clk  in  1  clock
reset  in  1  reset, asynchronous, active-low
mode  in  1  1 = sparse, 0 = dense; sampled on kernel accept
clear  in  1  synchronous abort; returns FSM to IDLE
in_valid  in  1  dense kernel valid
in_ready  out  1  block can accept a kernel
wei_array_full  in  72  kernel; position p = 3*row+col occupies bits [8p+7:8p]
wr_req_wei_flag  out  1  one-cycle flag write strobe
wr_data_wei_flag  out  9  flag mask; position p maps to bit 8-p (row0 = [8:6], col0 = MSB of the group)
row_val_num  out  6  {cnt_row2, cnt_row1, cnt_row0}, each 0..3
wei_out  out  8  streamed weight
wei_out_row  out  2  row of wei_out
wei_out_col  out  2  col of wei_out
wei_out_valid  out  1  stream beat valid
wei_out_ready  in  1  downstream ready
wei_out_last  out  1  final beat of kernel
kernel_done  out  1  one-cycle pulse when kernel fully emitted
busy  out  1  state != IDLE

Behaviour:
- Reset: every output is 0, with one exception: in_ready is 1 once reset deasserts (IDLE). Internal kernel, mask and mode registers are cleared.
- FSM states: IDLE, FLAG, STREAM.
- IDLE:
  - in_ready = 1 (0 when clear = 1).
  - On in_valid && in_ready: register the kernel and mode, compute the mask, go to FLAG.
- Mask computation:
  - Bit (8-p) = (weight p != 0) when mode = 1.
  - All ones when mode = 0.
- FLAG (exactly 1 cycle):
  - wr_req_wei_flag = 1; wr_data_wei_flag and row_val_num hold the kernel's values.
  - row_val_num stays stable until the next accept.
  - If the mask is 0: go to IDLE and pulse kernel_done in the same FLAG cycle.
  - Otherwise go to STREAM.
- STREAM:
  - wei_out_valid = 1. wei_out, row and col come from the lowest set position p in the remaining mask.
  - On wei_out_valid && wei_out_ready: clear that position. Next beat appears the following cycle with no bubbles.
  - wei_out_last = 1 when exactly one position remains.
  - On the last beat's handshake: kernel_done pulses in that cycle, and the next state is IDLE.
- Backpressure: while wei_out_ready = 0, wei_out, wei_out_row, wei_out_col, wei_out_valid and wei_out_last hold stable.
- Latency:
  - Accept edge to wr_req_wei_flag: 1 cycle.
  - Accept to first beat: 2 cycles.
  - Sparse kernel with N nonzeros and ready held high: N beats, next accept possible N+2 cycles after the previous accept.
- Counts: each row count is the popcount of its 3 mask bits (2 bits, max 3). The total (4 bits, max 9) is internal only.
- Outside STREAM, wei_out, wei_out_row and wei_out_col are 0.
- clear:
  - Highest priority in all states.
  - Next state is IDLE; no wr_req or kernel_done is generated.
  - A beat presented in the clear cycle is discarded, even if handshaken.
- in_valid while busy is ignored (in_ready = 0); no kernel is lost or overwritten.
- mode changes while busy do not affect the current kernel.

Test Plan:
- Sparse, weights p0..p8 = {5,0,0,0,7,0,0,0,9}, ready = 1:
  - 1 cycle after accept: wr_req = 1, flag = 9'h111, row_val_num = 6'b01_01_01.
  - Then beats 5(0,0), 7(1,1), 9(2,2), with last on the beat carrying 9.
  - kernel_done on that beat; in_ready = 1 on the next cycle.
- All-zero kernel, mode = 1:
  - flag = 9'h000, row_val_num = 0.
  - wei_out_valid never asserts; kernel_done pulses in the FLAG cycle.
- Dense mode, kernel {0,1,0,2,0,3,0,4,0}:
  - flag = 9'h1FF, row_val_num = 6'b11_11_11.
  - 9 beats in order 0,1,0,2,0,3,0,4,0, last on the 9th.
- Backpressure, kernel p1 = 6, p2 = 8, others 0:
  - Drop wei_out_ready for 3 cycles on the first beat; wei_out = 6, row 0, col 1 stays stable.
  - On release: beat 8 (0,2) with last. flag = 9'h0C0, row_val_num = 6'b00_00_10.
- Abort/reset:
  - clear on the second STREAM beat: next cycle IDLE, in_ready = 1, no kernel_done.
  - Async reset asserted mid-STREAM: all outputs 0 immediately.
  - A new kernel accepted afterwards streams correctly.
- Busy input: in_valid held high with a second kernel during STREAM. It is accepted only in IDLE, and its flag follows the first kernel's kernel_done by exactly 2 cycles.

Source files
------------

// File: rtl/weight_compress.sv
// weight_compress: sparse encoder for one dense 3x3 kernel of weights.
// A kernel is accepted on in_valid/in_ready. The next cycle (FLAG) emits
// the nonzero mask and the per-row counts with a single write strobe. After
// that the block streams the selected weights in raster order over a
// valid/ready port. In dense mode (mode = 0) every weight is selected.
//
// Ports:
//   clk, reset         clock; asynchronous active-low reset
//   mode               1 = sparse, 0 = dense; sampled when a kernel is accepted
//   clear              synchronous abort back to IDLE (highest priority)
//   in_valid/in_ready  dense kernel handshake; wei_array_full holds position p at [8p+7:8p]
//   wr_req_wei_flag    one-cycle strobe for wr_data_wei_flag (position p -> bit 8-p)
//   row_val_num        {cnt_row2, cnt_row1, cnt_row0}
//   wei_out*           weight stream: data, row, col, valid, ready, last
//   kernel_done        one-cycle pulse when the kernel is fully emitted
//   busy               FSM is not in IDLE
module weight_compress #(
    parameter int DATA_WIDTH      = 8,
    parameter int KERNEL_WIDTH    = 3,
    parameter int KERNEL_SIZE     = 9,
    parameter int WEI_INDEX_WIDTH = 2
) (
    input  logic                                    clk,
    input  logic                                    reset,
    input  logic                                    mode,
    input  logic                                    clear,
    input  logic                                    in_valid,
    output logic                                    in_ready,
    input  logic [DATA_WIDTH*KERNEL_SIZE-1:0]       wei_array_full,
    output logic                                    wr_req_wei_flag,
    output logic [KERNEL_SIZE-1:0]                  wr_data_wei_flag,
    output logic [KERNEL_WIDTH*WEI_INDEX_WIDTH-1:0] row_val_num,
    output logic [DATA_WIDTH-1:0]                   wei_out,
    output logic [WEI_INDEX_WIDTH-1:0]              wei_out_row,
    output logic [WEI_INDEX_WIDTH-1:0]              wei_out_col,
    output logic                                    wei_out_valid,
    input  logic                                    wei_out_ready,
    output logic                                    wei_out_last,
    output logic                                    kernel_done,
    output logic                                    busy
);

    localparam int CW = $clog2(KERNEL_SIZE + 1);

    typedef enum logic [1:0] {IDLE, FLAG, STREAM} state_t;

    state_t                                  r_state;
    logic [DATA_WIDTH*KERNEL_SIZE-1:0]       r_kernel;
    logic [KERNEL_SIZE-1:0]                  r_flag;
    logic [KERNEL_SIZE-1:0]                  r_pend;     // bit p set: position p not yet sent
    logic [KERNEL_WIDTH*WEI_INDEX_WIDTH-1:0] r_row_cnt;
    logic [CW-1:0]                           r_left;     // beats remaining in this kernel

    logic [KERNEL_SIZE-1:0]                  w_mask_pos;
    logic [KERNEL_SIZE-1:0]                  w_flag;
    logic [KERNEL_WIDTH*WEI_INDEX_WIDTH-1:0] w_row_cnt;
    logic [CW-1:0]                           w_total;
    logic [KERNEL_SIZE-1:0]                  w_sel_oh;
    logic [DATA_WIDTH-1:0]                   w_sel_wei;
    logic [WEI_INDEX_WIDTH-1:0]              w_sel_row;
    logic [WEI_INDEX_WIDTH-1:0]              w_sel_col;
    logic                                    w_found;
    logic                                    w_accept;
    logic                                    w_hs;
    logic                                    w_one_left;

    // Mask and counts of the kernel on the input port, indexed by position
    always_comb begin
        w_mask_pos = '0;
        w_flag     = '0;
        w_row_cnt  = '0;
        w_total    = '0;
        for (int unsigned p = 0; p < KERNEL_SIZE; p++) begin
            w_mask_pos[p] = !mode || (wei_array_full[p*DATA_WIDTH +: DATA_WIDTH] != '0);
            w_flag[KERNEL_SIZE-1-p] = w_mask_pos[p];
        end
        for (int unsigned r = 0; r < KERNEL_WIDTH; r++) begin
            for (int unsigned c = 0; c < KERNEL_WIDTH; c++) begin
                if (w_mask_pos[r*KERNEL_WIDTH+c]) begin
                    w_row_cnt[r*WEI_INDEX_WIDTH +: WEI_INDEX_WIDTH] =
                        w_row_cnt[r*WEI_INDEX_WIDTH +: WEI_INDEX_WIDTH] + 1'b1;
                    w_total = w_total + 1'b1;
                end
            end
        end
    end

    // Lowest pending position in raster order
    always_comb begin
        w_found   = 1'b0;
        w_sel_oh  = '0;
        w_sel_wei = '0;
        w_sel_row = '0;
        w_sel_col = '0;
        for (int unsigned r = 0; r < KERNEL_WIDTH; r++) begin
            for (int unsigned c = 0; c < KERNEL_WIDTH; c++) begin
                if (r_pend[r*KERNEL_WIDTH+c] && !w_found) begin
                    w_found                     = 1'b1;
                    w_sel_oh[r*KERNEL_WIDTH+c]  = 1'b1;
                    w_sel_wei = r_kernel[(r*KERNEL_WIDTH+c)*DATA_WIDTH +: DATA_WIDTH];
                    w_sel_row = WEI_INDEX_WIDTH'(r);
                    w_sel_col = WEI_INDEX_WIDTH'(c);
                end
            end
        end
    end

    // Output decode; in_ready is gated by reset so it stays low while reset is held
    always_comb begin
        w_one_left       = (r_left == CW'(1));
        busy             = (r_state != IDLE);
        in_ready         = reset && (r_state == IDLE) && !clear;
        w_accept         = in_valid && in_ready;
        wei_out_valid    = (r_state == STREAM);
        w_hs             = wei_out_valid && wei_out_ready;
        wei_out          = wei_out_valid ? w_sel_wei : '0;
        wei_out_row      = wei_out_valid ? w_sel_row : '0;
        wei_out_col      = wei_out_valid ? w_sel_col : '0;
        wei_out_last     = wei_out_valid && w_one_left;
        wr_req_wei_flag  = (r_state == FLAG) && !clear;
        wr_data_wei_flag = r_flag;
        row_val_num      = r_row_cnt;
        kernel_done      = !clear && (((r_state == FLAG) && (r_left == '0)) ||
                                      (w_hs && w_one_left));
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= IDLE;
            r_kernel  <= '0;
            r_flag    <= '0;
            r_pend    <= '0;
            r_row_cnt <= '0;
            r_left    <= '0;
        end else if (clear) begin
            r_state <= IDLE;
            r_pend  <= '0;
            r_left  <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_kernel  <= wei_array_full;
                        r_flag    <= w_flag;
                        r_pend    <= w_mask_pos;
                        r_row_cnt <= w_row_cnt;
                        r_left    <= w_total;
                        r_state   <= FLAG;
                    end
                end
                FLAG: begin
                    r_state <= (r_left == '0) ? IDLE : STREAM;
                end
                STREAM: begin
                    if (wei_out_ready) begin
                        r_pend <= r_pend & ~w_sel_oh;
                        r_left <= r_left - 1'b1;
                        if (w_one_left) r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_weight_compress.sv
// Self-checking bench for weight_compress: directed scenarios plus randomized
// kernels and backpressure, compared against a position-list reference model.
module tb_weight_compress;

    logic        clk;
    logic        reset;
    logic        mode;
    logic        clear;
    logic        in_valid;
    logic        in_ready;
    logic [71:0] wei_array_full;
    logic        wr_req_wei_flag;
    logic [8:0]  wr_data_wei_flag;
    logic [5:0]  row_val_num;
    logic [7:0]  wei_out;
    logic [1:0]  wei_out_row;
    logic [1:0]  wei_out_col;
    logic        wei_out_valid;
    logic        wei_out_ready;
    logic        wei_out_last;
    logic        kernel_done;
    logic        busy;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic [7:0] w;
        logic [1:0] row;
        logic [1:0] col;
    } beat_t;

    beat_t      exp_q[$];
    logic [8:0] exp_flag;
    logic [5:0] exp_rows;
    logic [8:0] g_flag;
    logic [5:0] g_rows;

    weight_compress #(
        .DATA_WIDTH      (8),
        .KERNEL_WIDTH    (3),
        .KERNEL_SIZE     (9),
        .WEI_INDEX_WIDTH (2)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .mode             (mode),
        .clear            (clear),
        .in_valid         (in_valid),
        .in_ready         (in_ready),
        .wei_array_full   (wei_array_full),
        .wr_req_wei_flag  (wr_req_wei_flag),
        .wr_data_wei_flag (wr_data_wei_flag),
        .row_val_num      (row_val_num),
        .wei_out          (wei_out),
        .wei_out_row      (wei_out_row),
        .wei_out_col      (wei_out_col),
        .wei_out_valid    (wei_out_valid),
        .wei_out_ready    (wei_out_ready),
        .wei_out_last     (wei_out_last),
        .kernel_done      (kernel_done),
        .busy             (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: got no completion, want completion within time limit");
        $fatal(1, "watchdog expired");
    end

    // Reference: list of selected positions in raster order, flag bit 8-p, row popcounts
    task automatic build_model(input logic [71:0] kv, input logic m);
        int    cnt[3];
        beat_t b;
        logic [7:0] w;
        exp_q.delete();
        exp_flag = '0;
        cnt[0] = 0; cnt[1] = 0; cnt[2] = 0;
        for (int p = 0; p < 9; p++) begin
            w = kv[8*p +: 8];
            if (!m || w != 8'd0) begin
                exp_flag[8-p] = 1'b1;
                cnt[p/3]++;
                b.w   = w;
                b.row = 2'(p / 3);
                b.col = 2'(p % 3);
                exp_q.push_back(b);
            end
        end
        exp_rows = {2'(cnt[2]), 2'(cnt[1]), 2'(cnt[0])};
    endtask

    function automatic logic [71:0] rand_kernel();
        logic [71:0] k;
        k = '0;
        for (int p = 0; p < 9; p++)
            if ($urandom_range(0, 1) == 1) k[8*p +: 8] = 8'($urandom_range(1, 255));
        return k;
    endfunction

    // Entered at the negedge of the FLAG cycle; returns after the IDLE cycle check
    task automatic check_stream(input logic [71:0] kv, input logic m,
                                input int hold_first, input bit rand_bp);
        int   cyc;
        int   held;
        bit   first;
        logic rdy;
        logic [16:0] obs;
        logic [16:0] expv;
        build_model(kv, m);
        #1;
        n_tests++;
        if ({wr_req_wei_flag, wr_data_wei_flag, row_val_num, kernel_done, wei_out_valid, busy} !==
            {1'b1, exp_flag, exp_rows, (exp_q.size() == 0), 1'b0, 1'b1}) begin
            n_fail++;
            $display("FAIL flag_phase: got req=%b flag=%h rows=%b done=%b valid=%b busy=%b want req=1 flag=%h rows=%b done=%b valid=0 busy=1",
                     wr_req_wei_flag, wr_data_wei_flag, row_val_num, kernel_done, wei_out_valid, busy,
                     exp_flag, exp_rows, (exp_q.size() == 0));
        end
        g_flag = wr_data_wei_flag;
        g_rows = row_val_num;
        cyc = 0; held = 0; first = 1'b1;
        while (exp_q.size() > 0 && cyc < 500) begin
            @(negedge clk);
            if (!in_valid) mode = 1'($urandom);
            if (first && held < hold_first) rdy = 1'b0;
            else if (rand_bp)               rdy = ($urandom_range(0, 3) != 0);
            else                            rdy = 1'b1;
            wei_out_ready = rdy;
            #1;
            obs  = {wei_out_valid, wei_out, wei_out_row, wei_out_col, wei_out_last,
                    wr_req_wei_flag, kernel_done, in_ready};
            expv = {1'b1, exp_q[0].w, exp_q[0].row, exp_q[0].col, (exp_q.size() == 1),
                    1'b0, (rdy && exp_q.size() == 1), 1'b0};
            n_tests++;
            if (obs !== expv) begin
                n_fail++;
                $display("FAIL stream_beat: got {v,w,r,c,last,req,done,rdy}=%h want %h (ready=%b)",
                         obs, expv, rdy);
            end
            if (rdy) begin
                void'(exp_q.pop_front());
                first = 1'b0;
            end else if (first) begin
                held++;
            end
            cyc++;
        end
        if (exp_q.size() != 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL stream_timeout: got %0d beats left want 0", exp_q.size());
        end
        @(negedge clk);
        wei_out_ready = 1'b1;
        #1;
        n_tests++;
        if ({busy, in_ready, wei_out_valid, kernel_done, wr_req_wei_flag, wei_out} !== {5'b01000, 8'd0}) begin
            n_fail++;
            $display("FAIL idle_after: got busy=%b in_ready=%b valid=%b done=%b req=%b wei=%h want busy=0 in_ready=1 others 0",
                     busy, in_ready, wei_out_valid, kernel_done, wr_req_wei_flag, wei_out);
        end
    endtask

    task automatic run_kernel(input logic [71:0] kv, input logic m,
                              input int hold_first, input bit rand_bp);
        @(negedge clk);
        wei_array_full = kv;
        mode           = m;
        in_valid       = 1'b1;
        wei_out_ready  = 1'b1;
        #1;
        n_tests++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL accept_ready: got in_ready=%b want 1", in_ready);
        end
        @(negedge clk);
        in_valid       = 1'b0;
        wei_array_full = rand_kernel();
        mode           = 1'($urandom);
        check_stream(kv, m, hold_first, rand_bp);
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        #1;
        n_tests++;
        if ({in_ready, wr_req_wei_flag, wr_data_wei_flag, row_val_num, wei_out, wei_out_row,
             wei_out_col, wei_out_valid, wei_out_last, kernel_done, busy} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got in_ready=%b flag=%h rows=%b wei=%h valid=%b busy=%b want all 0",
                     in_ready, wr_data_wei_flag, row_val_num, wei_out, wei_out_valid, busy);
        end
        @(negedge clk);
        reset = 1'b1;
        #1;
        n_tests++;
        if ({in_ready, busy, wr_req_wei_flag, wei_out_valid, kernel_done} !== 5'b10000) begin
            n_fail++;
            $display("FAIL reset_release: got in_ready=%b busy=%b req=%b valid=%b done=%b want in_ready=1 others 0",
                     in_ready, busy, wr_req_wei_flag, wei_out_valid, kernel_done);
        end
    endtask

    task automatic test_sparse();
        run_kernel({8'd9, 8'd0, 8'd0, 8'd0, 8'd7, 8'd0, 8'd0, 8'd0, 8'd5}, 1'b1, 0, 1'b0);
        n_tests++;
        if ({g_flag, g_rows} !== {9'h111, 6'b01_01_01}) begin
            n_fail++;
            $display("FAIL sparse_flag: got flag=%h rows=%b want flag=111 rows=010101", g_flag, g_rows);
        end
    endtask

    task automatic test_all_zero();
        run_kernel(72'd0, 1'b1, 0, 1'b0);
        n_tests++;
        if ({g_flag, g_rows} !== 15'd0) begin
            n_fail++;
            $display("FAIL zero_flag: got flag=%h rows=%b want 0", g_flag, g_rows);
        end
    endtask

    task automatic test_dense();
        run_kernel({8'd0, 8'd4, 8'd0, 8'd3, 8'd0, 8'd2, 8'd0, 8'd1, 8'd0}, 1'b0, 0, 1'b0);
        n_tests++;
        if ({g_flag, g_rows} !== {9'h1FF, 6'b11_11_11}) begin
            n_fail++;
            $display("FAIL dense_flag: got flag=%h rows=%b want flag=1ff rows=111111", g_flag, g_rows);
        end
    endtask

    task automatic test_backpressure();
        run_kernel({8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd8, 8'd6, 8'd0}, 1'b1, 3, 1'b0);
        n_tests++;
        if ({g_flag, g_rows} !== {9'h0C0, 6'b00_00_10}) begin
            n_fail++;
            $display("FAIL bp_flag: got flag=%h rows=%b want flag=0c0 rows=000010", g_flag, g_rows);
        end
    endtask

    task automatic test_clear();
        @(negedge clk);
        wei_array_full = {48'd0, 8'd3, 8'd2, 8'd1};
        mode = 1'b1; in_valid = 1'b1; wei_out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        #1;
        n_tests++;
        if ({wei_out_valid, wei_out} !== {1'b1, 8'd1}) begin
            n_fail++;
            $display("FAIL clear_beat1: got valid=%b wei=%h want valid=1 wei=01", wei_out_valid, wei_out);
        end
        @(negedge clk);
        clear = 1'b1;
        #1;
        n_tests++;
        if ({kernel_done, in_ready, wr_req_wei_flag, wei_out} !== {3'b000, 8'd2}) begin
            n_fail++;
            $display("FAIL clear_cycle: got done=%b in_ready=%b req=%b wei=%h want done=0 in_ready=0 req=0 wei=02",
                     kernel_done, in_ready, wr_req_wei_flag, wei_out);
        end
        @(negedge clk);
        clear = 1'b0;
        #1;
        n_tests++;
        if ({busy, in_ready, wei_out_valid, kernel_done, wei_out} !== {4'b0100, 8'd0}) begin
            n_fail++;
            $display("FAIL clear_idle: got busy=%b in_ready=%b valid=%b done=%b wei=%h want busy=0 in_ready=1 others 0",
                     busy, in_ready, wei_out_valid, kernel_done, wei_out);
        end
        run_kernel(rand_kernel(), 1'b1, 0, 1'b0);
    endtask

    task automatic test_async_reset();
        @(negedge clk);
        wei_array_full = {8'd0, 8'd0, 8'd44, 8'd0, 8'd33, 8'd0, 8'd22, 8'd0, 8'd11};
        mode = 1'b1; in_valid = 1'b1; wei_out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        #3;
        reset = 1'b0;
        #1;
        n_tests++;
        if ({in_ready, wr_req_wei_flag, wr_data_wei_flag, row_val_num, wei_out, wei_out_row,
             wei_out_col, wei_out_valid, wei_out_last, kernel_done, busy} !== '0) begin
            n_fail++;
            $display("FAIL async_reset: got in_ready=%b flag=%h rows=%b wei=%h valid=%b busy=%b want all 0",
                     in_ready, wr_data_wei_flag, row_val_num, wei_out, wei_out_valid, busy);
        end
        @(negedge clk);
        reset = 1'b1;
        #1;
        n_tests++;
        if ({in_ready, busy} !== 2'b10) begin
            n_fail++;
            $display("FAIL async_release: got in_ready=%b busy=%b want 1 0", in_ready, busy);
        end
        run_kernel({8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd77, 8'd0, 8'd0, 8'd66}, 1'b1, 0, 1'b0);
    endtask

    // Second kernel is held on the input from the first FLAG cycle onward
    task automatic test_back_to_back();
        logic [71:0] ka;
        logic [71:0] kb;
        ka = {8'd0, 8'd12, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd34, 8'd56};
        kb = rand_kernel();
        @(negedge clk);
        wei_array_full = ka; mode = 1'b1; in_valid = 1'b1; wei_out_ready = 1'b1;
        @(negedge clk);
        wei_array_full = kb;
        mode = 1'b0;
        check_stream(ka, 1'b1, 0, 1'b0);
        @(negedge clk);
        in_valid = 1'b0;
        check_stream(kb, 1'b0, 0, 1'b1);
    endtask

    task automatic test_random();
        for (int i = 0; i < 30; i++)
            run_kernel((i % 10 == 9) ? 72'd0 : rand_kernel(), 1'($urandom), $urandom_range(0, 2), 1'b1);
    endtask

    initial begin
        reset = 1'b0; mode = 1'b0; clear = 1'b0; in_valid = 1'b0;
        wei_array_full = '0; wei_out_ready = 1'b0;
        test_reset();
        test_sparse();
        test_all_zero();
        test_dense();
        test_backpressure();
        test_clear();
        test_async_reset();
        test_back_to_back();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
